mem_arbiter: RTL and testbench

- Shares one single-ported unified memory between the fetch stage (IF requester) and the memory stage (DM requester) of the pipelined RV32 core.
- Serialises accesses through a fixed-latency memory and returns each response to its owner.
- Produces per-requester stall signals that drive the pipeline-register enables and the PC enable.
- Sits between pc_reg/pip_reg_d on the fetch side, pip_reg_m on the data side, and the memory macro.

---
 rtl/mem_arbiter.sv | 166 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Shares one single-ported, fixed-latency memory between the
//               fetch (IF) and data (DM) requesters. Accesses are serialised
//               and ownership alternates on contention. Responses go back to
//               the owner, and per-requester stall signals are produced.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_LATENCY = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  // fetch requester
  input  logic                  if_req_i,
  input  logic [ADDR_WIDTH-1:0] if_addr_i,
  output logic [DATA_WIDTH-1:0] if_rdata_o,
  output logic                  if_rvalid_o,
  // data requester
  input  logic                  dm_req_i,
  input  logic                  dm_we_i,
  input  logic [ADDR_WIDTH-1:0] dm_addr_i,
  input  logic [DATA_WIDTH-1:0] dm_wdata_i,
  output logic [DATA_WIDTH-1:0] dm_rdata_o,
  output logic                  dm_rvalid_o,
  // memory side
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  // pipeline stalls
  output logic                  stall_f_o,
  output logic                  stall_m_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam logic       OWN_IF = 1'b0;
  localparam logic       OWN_DM = 1'b1;
  localparam logic [2:0] LAT    = 3'(MEM_LATENCY);

  state_t                state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic                  owner_q, owner_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_WIDTH-1:0] dm_rdata_q, dm_rdata_d;

  logic                  grant_dm;
  logic [DATA_WIDTH-1:0] resp_data;

  // Winner selection: a lone request wins; on contention the side that did not win last time wins.
  always_comb begin
    grant_dm = 1'b0;
    if (if_req_i && dm_req_i) begin
      grant_dm = (last_grant_q == OWN_IF);
    end else begin
      grant_dm = dm_req_i;
    end
  end

  // Stores complete with a zero response word.
  always_comb begin
    resp_data = we_q ? '0 : mem_rdata_i;
  end

  // Next-state and datapath latch logic of the access sequencer.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    if_rdata_d   = if_rdata_q;
    dm_rdata_d   = dm_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (if_req_i || dm_req_i) begin
          owner_d      = grant_dm ? OWN_DM : OWN_IF;
          last_grant_d = grant_dm ? OWN_DM : OWN_IF;
          we_d         = grant_dm & dm_we_i;
          addr_d       = grant_dm ? dm_addr_i : if_addr_i;
          wdata_d      = grant_dm ? dm_wdata_i : '0;
          state_d      = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = 3'd1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == LAT) begin
          if (owner_q == OWN_DM) begin
            dm_rdata_d = resp_data;
          end else begin
            if_rdata_d = resp_data;
          end
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any in-flight access.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= ST_IDLE;
      last_grant_q <= OWN_IF;
      owner_q      <= OWN_IF;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= 3'd0;
      if_rdata_q   <= '0;
      dm_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      if_rdata_q   <= if_rdata_d;
      dm_rdata_q   <= dm_rdata_d;
    end
  end

  // Output decode; stalls are gated by reset so every output is quiet while it is held.
  always_comb begin
    mem_req_o   = (state_q == ST_ISSUE);
    mem_we_o    = (state_q == ST_ISSUE) & we_q;
    mem_addr_o  = addr_q;
    mem_wdata_o = wdata_q;
    if_rvalid_o = (state_q == ST_RESP) & (owner_q == OWN_IF);
    dm_rvalid_o = (state_q == ST_RESP) & (owner_q == OWN_DM);
    if_rdata_o  = if_rdata_q;
    dm_rdata_o  = dm_rdata_q;
    stall_f_o   = rst_i & if_req_i & ~if_rvalid_o;
    stall_m_o   = rst_i & dm_req_i & ~dm_rvalid_o;
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter: a transaction-level
//               scheduler model predicts every output each cycle; directed
//               scenarios plus randomized requesters, flushes and resets.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  localparam int L = 2;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        if_req_i, dm_req_i, dm_we_i;
  logic [31:0] if_addr_i, dm_addr_i, dm_wdata_i, mem_rdata_i;
  logic [31:0] if_rdata_o, dm_rdata_o, mem_addr_o, mem_wdata_o;
  logic        if_rvalid_o, dm_rvalid_o, mem_req_o, mem_we_o, stall_f_o, stall_m_o;

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(L)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_rvalid_o(if_rvalid_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
    .dm_rdata_o(dm_rdata_o), .dm_rvalid_o(dm_rvalid_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
    .stall_f_o(stall_f_o), .stall_m_o(stall_m_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- memories: bench-side macro and model mirror ----------------
  logic [31:0] tb_mem  [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  function automatic logic [31:0] seed_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [31:0] tb_rd(input logic [31:0] a);
    return tb_mem.exists(a) ? tb_mem[a] : seed_word(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : seed_word(a);
  endfunction

  int          due_q[$];
  logic [31:0] dat_q[$];

  // ---------------- transaction-level reference model ----------------
  int          p = 0;           // current period index
  int          issue_p = -1, resp_p = -1, next_arb = 0;
  logic        m_owner, m_we, last_g;   // owner: 0 = IF, 1 = DM
  logic [31:0] m_addr, m_wdata, m_data;
  logic [31:0] exp_if_rdata, exp_dm_rdata;

  // samples of DUT behaviour for stimulus reaction and directed logs
  logic        s_mem_req, s_mem_we, s_if_rv, s_dm_rv;
  logic [31:0] s_addr, s_wdata;
  int          iss_p[$];
  logic [31:0] iss_addr[$];
  logic        iss_we[$];
  int          rv_p[$];
  logic        rv_own[$];
  logic [31:0] rv_data[$];

  int agent_mode = 0;   // 0: directed only, 1: drop request on rvalid, 2: random
  int rst_hold   = 0;

  task automatic model_eval();
    logic exp_if_rv, exp_dm_rv, winner;
    if (!rst_i) begin
      issue_p = -1; resp_p = -1; next_arb = 0; last_g = 1'b0;
      exp_if_rdata = '0; exp_dm_rdata = '0;
      chk("rst_mem_req",  mem_req_o,   1'b0);
      chk("rst_mem_we",   mem_we_o,    1'b0);
      chk("rst_mem_addr", mem_addr_o,  32'h0);
      chk("rst_mem_wd",   mem_wdata_o, 32'h0);
      chk("rst_if_rv",    if_rvalid_o, 1'b0);
      chk("rst_dm_rv",    dm_rvalid_o, 1'b0);
      chk("rst_if_rd",    if_rdata_o,  32'h0);
      chk("rst_dm_rd",    dm_rdata_o,  32'h0);
      chk("rst_stall_f",  stall_f_o,   1'b0);
      chk("rst_stall_m",  stall_m_o,   1'b0);
    end else begin
      chk("mem_req", mem_req_o, (p == issue_p));
      if (p == issue_p) begin
        chk("mem_we",   mem_we_o,   m_we);
        chk("mem_addr", mem_addr_o, m_addr);
        if (m_we) chk("mem_wdata", mem_wdata_o, m_wdata);
        m_data = m_we ? 32'h0 : ref_rd(m_addr);
        if (m_we) ref_mem[m_addr] = m_wdata;
      end else begin
        chk("mem_we_idle", mem_we_o, 1'b0);
      end
      exp_if_rv = (p == resp_p) && !m_owner;
      exp_dm_rv = (p == resp_p) &&  m_owner;
      if (exp_if_rv) exp_if_rdata = m_data;
      if (exp_dm_rv) exp_dm_rdata = m_data;
      chk("if_rvalid", if_rvalid_o, exp_if_rv);
      chk("dm_rvalid", dm_rvalid_o, exp_dm_rv);
      chk("if_rdata",  if_rdata_o,  exp_if_rdata);
      chk("dm_rdata",  dm_rdata_o,  exp_dm_rdata);
      chk("stall_f",   stall_f_o,   if_req_i & ~exp_if_rv);
      chk("stall_m",   stall_m_o,   dm_req_i & ~exp_dm_rv);
      // grant decision at the edge ending this period
      if (p >= next_arb && (if_req_i || dm_req_i)) begin
        winner   = (if_req_i && dm_req_i) ? ~last_g : dm_req_i;
        last_g   = winner;
        m_owner  = winner;
        m_we     = winner & dm_we_i;
        m_addr   = winner ? dm_addr_i : if_addr_i;
        m_wdata  = dm_wdata_i;
        issue_p  = p + 1;
        resp_p   = p + 2 + L;
        next_arb = p + 3 + L;
      end
    end
  endtask

  function automatic logic [31:0] rand_addr();
    return {26'h0, 4'($urandom_range(0, 15)), 2'b00};
  endfunction

  // One clock period: check at negedge, then after the edge update memory and stimulus.
  task automatic tick();
    @(negedge clk);
    s_mem_req = mem_req_o; s_mem_we = mem_we_o; s_addr = mem_addr_o; s_wdata = mem_wdata_o;
    s_if_rv = if_rvalid_o; s_dm_rv = dm_rvalid_o;
    if (mem_req_o) begin iss_p.push_back(p); iss_addr.push_back(mem_addr_o); iss_we.push_back(mem_we_o); end
    if (if_rvalid_o) begin rv_p.push_back(p); rv_own.push_back(1'b0); rv_data.push_back(if_rdata_o); end
    if (dm_rvalid_o) begin rv_p.push_back(p); rv_own.push_back(1'b1); rv_data.push_back(dm_rdata_o); end
    model_eval();
    @(posedge clk);
    #1;
    p++;
    if (s_mem_req) begin
      if (s_mem_we) tb_mem[s_addr] = s_wdata;
      else begin due_q.push_back(p - 1 + L); dat_q.push_back(tb_rd(s_addr)); end
    end
    while (due_q.size() > 0 && due_q[0] < p) begin void'(due_q.pop_front()); void'(dat_q.pop_front()); end
    if (due_q.size() > 0 && due_q[0] == p) begin
      void'(due_q.pop_front());
      mem_rdata_i = dat_q.pop_front();
    end else begin
      mem_rdata_i = $urandom();
    end
    if (agent_mode == 1) begin
      if (if_req_i && s_if_rv) if_req_i = 1'b0;
      if (dm_req_i && s_dm_rv) dm_req_i = 1'b0;
    end else if (agent_mode == 2) begin
      if (rst_hold > 0) begin
        rst_hold--;
        if (rst_hold == 0) rst_i = 1'b1;
      end else if ($urandom_range(0, 99) == 0) begin
        rst_i = 1'b0;
        rst_hold = $urandom_range(1, 3);
      end
      if (if_req_i) begin
        if (s_if_rv || $urandom_range(0, 19) == 0) if_req_i = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        if_req_i = 1'b1; if_addr_i = rand_addr();
      end
      if (dm_req_i) begin
        if (s_dm_rv) dm_req_i = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        dm_req_i = 1'b1; dm_we_i = 1'($urandom_range(0, 1));
        dm_addr_i = rand_addr(); dm_wdata_i = $urandom();
      end
    end
  endtask

  task automatic clear_logs();
    iss_p.delete(); iss_addr.delete(); iss_we.delete();
    rv_p.delete(); rv_own.delete(); rv_data.delete();
  endtask

  task automatic do_reset();
    rst_i = 1'b0; if_req_i = 1'b0; dm_req_i = 1'b0; dm_we_i = 1'b0;
    tick();
    rst_i = 1'b1;
  endtask

  int base;

  initial begin
    rst_i = 1'b0; if_req_i = 1'b0; dm_req_i = 1'b0; dm_we_i = 1'b0;
    if_addr_i = '0; dm_addr_i = '0; dm_wdata_i = '0; mem_rdata_i = '0;
    tb_mem[32'h10]  = 32'h00500093;
    ref_mem[32'h10] = 32'h00500093;

    // reset held with random inputs
    for (int i = 0; i < 6; i++) begin
      if_req_i = 1'($urandom); dm_req_i = 1'($urandom); dm_we_i = 1'($urandom);
      if_addr_i = $urandom(); dm_addr_i = $urandom(); dm_wdata_i = $urandom();
      tick();
    end
    rst_i = 1'b1; if_req_i = 1'b0; dm_req_i = 1'b0; dm_we_i = 1'b0;
    clear_logs();
    for (int i = 0; i < 4; i++) tick();
    chk("idle_no_issue", 64'(iss_p.size()), 64'd0);

    // single fetch
    agent_mode = 1; clear_logs();
    base = p; if_req_i = 1'b1; if_addr_i = 32'h10;
    for (int i = 0; i < 8; i++) tick();
    chk("fetch_issue_n", 64'(iss_p.size()), 64'd1);
    chk("fetch_rv_n",    64'(rv_p.size()),  64'd1);
    if (iss_p.size() > 0) begin
      chk("fetch_issue_cyc", 64'(iss_p[0] - base), 64'd1);
      chk("fetch_issue_adr", iss_addr[0], 32'h10);
    end
    if (rv_p.size() > 0) begin
      chk("fetch_rv_cyc",  64'(rv_p[0] - base), 64'd4);
      chk("fetch_rv_data", rv_data[0], 32'h00500093);
    end

    // store
    clear_logs();
    base = p; dm_req_i = 1'b1; dm_we_i = 1'b1; dm_addr_i = 32'h100; dm_wdata_i = 32'hDEADBEEF;
    for (int i = 0; i < 8; i++) tick();
    chk("store_issue_n", 64'(iss_p.size()), 64'd1);
    chk("store_rv_n",    64'(rv_p.size()),  64'd1);
    if (iss_p.size() > 0) begin
      chk("store_issue_cyc", 64'(iss_p[0] - base), 64'd1);
      chk("store_issue_we",  iss_we[0], 1'b1);
    end
    if (rv_p.size() > 0) begin
      chk("store_rv_cyc",  64'(rv_p[0] - base), 64'd4);
      chk("store_rv_own",  rv_own[0], 1'b1);
      chk("store_rv_data", rv_data[0], 32'h0);
    end

    // contention held for four grants, first after reset
    agent_mode = 0;
    do_reset(); clear_logs();
    base = p; if_req_i = 1'b1; if_addr_i = 32'h20;
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h200;
    for (int i = 0; i < 20; i++) tick();
    chk("contend_issue_n", 64'(iss_p.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (iss_p.size() > i) begin
        chk("contend_issue_cyc", 64'(iss_p[i] - base), 64'(1 + 5 * i));
        chk("contend_issue_adr", iss_addr[i], (i % 2 == 0) ? 32'h200 : 32'h20);
      end
    end
    if_req_i = 1'b0; dm_req_i = 1'b0;
    for (int i = 0; i < 8; i++) tick();

    // fetch flushed after grant
    do_reset(); clear_logs();
    base = p; if_req_i = 1'b1; if_addr_i = 32'h30;
    tick(); tick();
    if_req_i = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("flush_issue_n", 64'(iss_p.size()), 64'd1);
    chk("flush_rv_n",    64'(rv_p.size()),  64'd1);
    if (rv_p.size() > 0) chk("flush_rv_cyc", 64'(rv_p[0] - base), 64'd4);

    // reset in the middle of a fetch
    clear_logs();
    base = p; if_req_i = 1'b1; if_addr_i = 32'h40;
    tick(); tick();
    rst_i = 1'b0; if_req_i = 1'b0;
    tick();
    rst_i = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("rstmid_rv_n", 64'(rv_p.size()), 64'd0);
    agent_mode = 1; clear_logs();
    base = p; if_req_i = 1'b1; if_addr_i = 32'h44;
    for (int i = 0; i < 8; i++) tick();
    chk("rstmid_new_rv_n", 64'(rv_p.size()), 64'd1);
    if (rv_p.size() > 0) chk("rstmid_new_rv_cyc", 64'(rv_p[0] - base), 64'd4);

    // randomized traffic with flushes and occasional resets
    agent_mode = 2;
    for (int i = 0; i < 500; i++) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
